// File: rtl/sa_scan_ctrl.sv
// sa_scan_ctrl: loads one scan chain, pulses capture, unloads the response.
// Define SA_SCAN_CMP_EN to add the registered response/expect mismatch flag.
module sa_scan_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
    input  logic                 CP,
    input  logic                 CDN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    // "expect" is a reserved word in SystemVerilog
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 SI,
    output logic                 SE,
    output logic                 busy,
    output logic                 done,
`ifdef SA_SCAN_CMP_EN
    output logic                 mismatch,
`endif
    output logic [CHAIN_LEN-1:0] response
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] resp_n;
    logic                 last;
    logic                 accept;
    logic                 shifting;
    logic                 se_n;
    logic                 busy_n;
    logic                 done_n;

    assign last     = (cnt == LAST);
    assign accept   = (state == IDLE) && start;
    assign shifting = (state == SHIFT_IN) || (state == SHIFT_OUT);
    assign resp_n   = {response[CHAIN_LEN-2:0], SO};

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (start) state_n = SHIFT_IN;
            SHIFT_IN:  if (last) state_n = CAPTURE;
            CAPTURE:   state_n = SHIFT_OUT;
            SHIFT_OUT: if (last) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        // outputs are registered, so they follow the state being entered
        se_n   = (state_n == SHIFT_IN) || (state_n == SHIFT_OUT);
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge CP) begin
        if (!CDN) begin
            state    <= IDLE;
            cnt      <= '0;
            sreg     <= '0;
            SI       <= 1'b0;
            SE       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
        end else begin
            state <= state_n;
            SE    <= se_n;
            busy  <= busy_n;
            done  <= done_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (shifting && !last) begin
                cnt <= cnt + 1'b1;
            end
            SI <= 1'b0;
            if (accept) begin
                SI       <= pattern[CHAIN_LEN-1];
                sreg     <= {pattern[CHAIN_LEN-2:0], 1'b0};
                response <= '0;
            end else if (state == SHIFT_IN && !last) begin
                SI   <= sreg[CHAIN_LEN-1];
                sreg <= {sreg[CHAIN_LEN-2:0], 1'b0};
            end
            if (state == SHIFT_OUT) begin
                response <= resp_n;
            end
        end
    end

`ifdef SA_SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q;

    always_ff @(posedge CP) begin
        if (!CDN) begin
            exp_q    <= '0;
            mismatch <= 1'b0;
        end else if (accept) begin
            exp_q    <= expected;
            mismatch <= 1'b0;
        end else if (state == SHIFT_OUT && last) begin
            mismatch <= |(resp_n ^ exp_q);
        end
    end
`else
    logic unused_expected;
    assign unused_expected = ^expected;
`endif

endmodule

// File: tb/tb_sa_scan_ctrl.sv
// tb_sa_scan_ctrl: scan-chain environment plus sequence-level reference model.
// Covers CHAIN_LEN=8 and a CHAIN_LEN=2 instance; honours SA_SCAN_CMP_EN.
module tb_sa_scan_ctrl;

    localparam int N  = 8;
    localparam int N2 = 2;

    logic         CP = 1'b0;
    logic         CDN = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] expected = '0;
    logic         SO;
    logic         SI;
    logic         SE;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic [N-1:0] chain = '0;
    logic         inv = 1'b0;

    logic          start2 = 1'b0;
    logic [N2-1:0] pattern2 = '0;
    logic [N2-1:0] expected2 = '0;
    logic          SO2;
    logic          SI2;
    logic          SE2;
    logic          busy2;
    logic          done2;
    logic [N2-1:0] response2;
    logic [N2-1:0] chain2 = '0;

`ifdef SA_SCAN_CMP_EN
    logic mismatch;
    logic mismatch2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sa_scan_ctrl #(.CHAIN_LEN(N)) dut (
        .CP(CP), .CDN(CDN), .start(start),
        .pattern(pattern), .expected(expected),
        .SO(SO), .SI(SI), .SE(SE),
        .busy(busy), .done(done),
`ifdef SA_SCAN_CMP_EN
        .mismatch(mismatch),
`endif
        .response(response)
    );

    sa_scan_ctrl #(.CHAIN_LEN(N2)) dut2 (
        .CP(CP), .CDN(CDN), .start(start2),
        .pattern(pattern2), .expected(expected2),
        .SO(SO2), .SI(SI2), .SE(SE2),
        .busy(busy2), .done(done2),
`ifdef SA_SCAN_CMP_EN
        .mismatch(mismatch2),
`endif
        .response(response2)
    );

    always #5 CP = ~CP;

    // scan flops: shift when SE, otherwise capture through identity or invert
    assign SO  = chain[N-1];
    assign SO2 = chain2[N2-1];
    always @(posedge CP) begin
        chain  <= SE ? {chain[N-2:0], SI} : (inv ? ~chain : chain);
        chain2 <= SE2 ? {chain2[N2-2:0], SI2} : chain2;
    end

    typedef struct {
        logic [N-1:0] pat;
        logic [N-1:0] exp_v;
        logic         iv;
        logic [N-1:0] resp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic model_resp_bit(input logic [N-1:0] p,
                                            input logic iv, input int i);
        return iv ? ~p[i] : p[i];
    endfunction

    function automatic logic [N-1:0] model_resp(input logic [N-1:0] p,
                                                input logic iv);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = model_resp_bit(p, iv, i);
        return r;
    endfunction

    // sequence cycle c (0 = first cycle after acceptance): shifting except capture/done
    function automatic logic se_at(input int c, input int n);
        return (c < n) || (c > n && c <= 2 * n);
    endfunction

    task automatic run_seq(input logic [N-1:0] p, input logic [N-1:0] e,
                           input logic iv, input logic [N-1:0] want,
                           input bit noise);
        logic si_want;
        inv      = iv;
        pattern  = p;
        expected = e;
        start    = 1'b1;
        @(posedge CP); #1;
        start = 1'b0;
        for (int c = 0; c <= 2 * N + 1; c++) begin
            si_want = 1'b0;
            if (c < N) si_want = p[N-1-c];
            chk("busy", busy, 1);
            chk("se", SE, se_at(c, N));
            chk("si", SI, si_want);
            chk("done", done, c == 2 * N + 1);
            if (c == 0) chk("resp_clr", response, 0);
            if (c == 2 * N + 1) begin
                chk("resp", response, want);
`ifdef SA_SCAN_CMP_EN
                chk("mismatch", mismatch, |(want ^ e));
`endif
            end
            if (noise) start = 1'($urandom_range(0, 1));
            @(posedge CP); #1;
        end
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("resp_hold", response, want);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] p;
        logic [N-1:0] e;
        logic         iv;
        bit           seen;
        int           k;

        vecs[0] = '{pat: 8'hA5, exp_v: 8'hA5, iv: 1'b0, resp: 8'hA5};
        vecs[1] = '{pat: 8'h0F, exp_v: 8'hF0, iv: 1'b1, resp: 8'hF0};
        vecs[2] = '{pat: 8'h0F, exp_v: 8'hF1, iv: 1'b1, resp: 8'hF0};
        vecs[3] = '{pat: 8'h81, exp_v: 8'h00, iv: 1'b0, resp: 8'h81};

        repeat (2) @(posedge CP);
        #1;
        chk("rst_se", SE, 0);
        chk("rst_si", SI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", response, 0);
`ifdef SA_SCAN_CMP_EN
        chk("rst_mm", mismatch, 0);
`endif
        CDN = 1'b1;
        @(posedge CP); #1;

        // two-flop chain corner
        pattern2  = 2'b10;
        expected2 = 2'b10;
        start2    = 1'b1;
        @(posedge CP); #1;
        start2 = 1'b0;
        for (int c = 0; c <= 2 * N2 + 1; c++) begin
            chk("n2_busy", busy2, 1);
            chk("n2_se", SE2, se_at(c, N2));
            chk("n2_si", SI2, (c == 0) ? 1 : 0);
            chk("n2_done", done2, c == 2 * N2 + 1);
            if (c == 2 * N2 + 1) begin
                chk("n2_resp", response2, 2'b10);
`ifdef SA_SCAN_CMP_EN
                chk("n2_mm", mismatch2, 0);
`endif
            end
            @(posedge CP); #1;
        end
        chk("n2_idle", busy2, 0);

        for (int i = 0; i < 4; i++) begin
            run_seq(vecs[i].pat, vecs[i].exp_v, vecs[i].iv, vecs[i].resp, i[0]);
        end

        // reset during SHIFT_OUT cycle 3 aborts without done
        inv     = 1'b0;
        pattern = 8'h3C;
        start   = 1'b1;
        @(posedge CP); #1;
        start = 1'b0;
        repeat (N + 4) @(posedge CP);
        #1;
        chk("pre_abort_busy", busy, 1);
        chk("pre_abort_se", SE, 1);
        CDN = 1'b0;
        @(posedge CP); #1;
        CDN = 1'b1;
        chk("abort_se", SE, 0);
        chk("abort_busy", busy, 0);
        chk("abort_resp", response, 0);
        chk("abort_done", done, 0);
`ifdef SA_SCAN_CMP_EN
        chk("abort_mm", mismatch, 0);
`endif
        seen = 1'b0;
        repeat (2 * N + 4) begin
            @(posedge CP); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        run_seq(8'h5A, 8'h5A, 1'b0, 8'h5A, 1'b0);

        // start held high: back-to-back runs, one idle cycle apart
        inv      = 1'b0;
        pattern  = 8'hC3;
        expected = 8'hC3;
        start    = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int r;
            @(posedge CP); #1;
            r = t % (2 * N + 3);
            chk("b2b_busy", busy, r <= 2 * N + 1);
            chk("b2b_done", done, r == 2 * N + 1);
            chk("b2b_se", SE, se_at(r, N));
            if (r == 0) chk("b2b_clr", response, 0);
            if (r == 2 * N + 1) chk("b2b_resp", response, 8'hC3);
        end
        start = 1'b0;
        for (k = 0; k < 3 * N && busy; k++) begin
            @(posedge CP); #1;
        end
        chk("b2b_drain", busy, 0);

        repeat (16) begin
            p  = N'($urandom);
            iv = 1'($urandom_range(0, 1));
            e  = $urandom_range(0, 1) ? model_resp(p, iv) : N'($urandom);
            run_seq(p, e, iv, model_resp(p, iv), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
